// File: rtl/change_dispenser.sv
// Actuator back end for the vending controller: runs the item motor, then pays out
// quarters one at a time, confirming each actuation by a sensor edge and faulting on timeout.
module change_dispenser #(
    parameter int NUM_CHOICES_SIZE = 3,
    parameter int CHANGE_SIZE      = 5,
    parameter int COIN_TIMEOUT     = 1000,
    parameter int ITEM_TIMEOUT     = 2000,
    parameter int COIN_GAP         = 4
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [CHANGE_SIZE-1:0]      i_change,
    input  logic [NUM_CHOICES_SIZE-1:0] i_item,
    input  logic                        i_coin_sense,
    input  logic                        i_item_drop,
    input  logic                        i_fault_clr,
    output logic [NUM_CHOICES_SIZE-1:0] o_motor,
    output logic                        o_hopper_en,
    output logic [CHANGE_SIZE-1:0]      o_coins_left,
    output logic                        o_busy,
    output logic                        o_done,
    output logic                        o_overrun,
    output logic                        o_fault
);
    localparam int TMAX = (COIN_TIMEOUT > ITEM_TIMEOUT) ? COIN_TIMEOUT : ITEM_TIMEOUT;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ITEM_RUN, S_COIN_RUN, S_COIN_WAIT, S_DONE, S_FAULT
    } state_t;

    state_t                      r_state, w_state_nxt;
    logic [CHANGE_SIZE-1:0]      r_cnt, w_cnt_nxt;
    logic [NUM_CHOICES_SIZE-1:0] r_item, w_item_nxt, w_item_sel;
    logic [TW-1:0]               r_tmr, w_tmr_nxt;
    logic                        r_coin_q, r_drop_q;
    logic                        w_coin_edge, w_drop_edge, w_load;
    logic [NUM_CHOICES_SIZE-1:0] r_motor;
    logic                        r_hopper, r_busy, r_done, r_overrun, r_fault;

    assign w_load      = (i_change != '0) || (i_item != '0);
    assign w_coin_edge = i_coin_sense & ~r_coin_q;
    assign w_drop_edge = i_item_drop & ~r_drop_q;

    // Lowest set bit at index >= 1 wins; bit 0 (refund) never drives a motor.
    always_comb begin
        w_item_sel = '0;
        for (int i = NUM_CHOICES_SIZE - 1; i >= 1; i--) begin
            if (i_item[i]) begin
                w_item_sel    = '0;
                w_item_sel[i] = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_item_nxt  = r_item;
        w_tmr_nxt   = '0;
        case (r_state)
            S_IDLE: begin
                if (w_load) begin
                    w_cnt_nxt  = i_change;
                    w_item_nxt = w_item_sel;
                    if (w_item_sel != '0)     w_state_nxt = S_ITEM_RUN;
                    else if (i_change != '0)  w_state_nxt = S_COIN_RUN;
                    else                      w_state_nxt = S_DONE;
                end
            end
            S_ITEM_RUN: begin
                w_tmr_nxt = r_tmr + 1'b1;
                if (w_drop_edge) begin
                    w_tmr_nxt   = '0;
                    w_state_nxt = (r_cnt != '0) ? S_COIN_RUN : S_DONE;
                end else if (r_tmr == TW'(ITEM_TIMEOUT - 1)) begin
                    w_state_nxt = S_FAULT;
                end
            end
            S_COIN_RUN: begin
                w_tmr_nxt = r_tmr + 1'b1;
                if (w_coin_edge) begin
                    w_tmr_nxt = '0;
                    if (r_cnt != '0) w_cnt_nxt = r_cnt - CHANGE_SIZE'(1);
                    // The last coin completes immediately; the gap only separates coins.
                    w_state_nxt = (r_cnt <= CHANGE_SIZE'(1)) ? S_DONE : S_COIN_WAIT;
                end else if (r_tmr == TW'(COIN_TIMEOUT - 1)) begin
                    w_state_nxt = S_FAULT;
                end
            end
            S_COIN_WAIT: begin
                w_tmr_nxt = r_tmr + 1'b1;
                if (r_tmr == TW'(COIN_GAP - 1)) begin
                    w_tmr_nxt   = '0;
                    w_state_nxt = (r_cnt != '0) ? S_COIN_RUN : S_DONE;
                end
            end
            S_DONE: begin
                w_item_nxt  = '0;
                w_state_nxt = S_IDLE;
            end
            S_FAULT: begin
                if (i_fault_clr) begin
                    w_cnt_nxt   = '0;
                    w_item_nxt  = '0;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_item    <= '0;
            r_tmr     <= '0;
            r_coin_q  <= 1'b0;
            r_drop_q  <= 1'b0;
            r_motor   <= '0;
            r_hopper  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
            r_fault   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_item    <= w_item_nxt;
            r_tmr     <= w_tmr_nxt;
            r_coin_q  <= i_coin_sense;
            r_drop_q  <= i_item_drop;
            // Outputs are decoded from next state so they line up with the state register.
            r_motor   <= (w_state_nxt == S_ITEM_RUN) ? w_item_nxt : '0;
            r_hopper  <= (w_state_nxt == S_COIN_RUN);
            r_busy    <= (w_state_nxt != S_IDLE);
            r_done    <= (w_state_nxt == S_DONE);
            r_overrun <= w_load && (r_state != S_IDLE);
            r_fault   <= (w_state_nxt == S_FAULT);
        end
    end

    assign o_motor      = r_motor;
    assign o_hopper_en  = r_hopper;
    assign o_coins_left = r_cnt;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_overrun    = r_overrun;
    assign o_fault      = r_fault;
endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: load-response vector table plus multi-cycle
// sequences for vending, refunds, timeout fault, overrun and terminal-cycle edge.
module tb_change_dispenser;
    logic       clk = 1'b0, rst = 1'b1;
    logic [4:0] change = '0;
    logic [2:0] item = '0;
    logic       coin_sense = 1'b0, item_drop = 1'b0, fault_clr = 1'b0;
    logic [2:0] motor;
    logic       hopper_en, busy, done, overrun, fault;
    logic [4:0] coins_left;

    int checks = 0, errors = 0, done_cnt = 0;

    change_dispenser dut (
        .i_clk(clk), .i_rst(rst), .i_change(change), .i_item(item),
        .i_coin_sense(coin_sense), .i_item_drop(item_drop), .i_fault_clr(fault_clr),
        .o_motor(motor), .o_hopper_en(hopper_en), .o_coins_left(coins_left),
        .o_busy(busy), .o_done(done), .o_overrun(overrun), .o_fault(fault)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (done) done_cnt++;

    typedef struct {
        logic [2:0] item;
        logic [4:0] change;
        logic [2:0] motor;
        logic       hopper;
        logic [4:0] coins;
        logic       done;
    } vec_t;
    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; change = '0; item = '0;
        coin_sense = 1'b0; item_drop = 1'b0; fault_clr = 1'b0;
        step(); step();
        rst = 1'b0;
        step();
    endtask

    task automatic chk_idle(input string name);
        chk({name, ".motor"}, 32'(motor), 0);
        chk({name, ".hopper"}, 32'(hopper_en), 0);
        chk({name, ".busy"}, 32'(busy), 0);
        chk({name, ".done"}, 32'(done), 0);
        chk({name, ".fault"}, 32'(fault), 0);
    endtask

    // Entered on the first hopper-high cycle; each coin window is hi cycles long.
    task automatic run_coins(input int n, input int hi, input string name);
        for (int c = n; c >= 1; c--) begin
            for (int k = 1; k < hi; k++) begin
                chk({name, ".hop_hi"}, 32'(hopper_en), 1);
                chk({name, ".motor0"}, 32'(motor), 0);
                step();
            end
            chk({name, ".hop_hi_last"}, 32'(hopper_en), 1);
            coin_sense = 1'b1;
            step();
            coin_sense = 1'b0;
            chk({name, ".hop_drop"}, 32'(hopper_en), 0);
            chk({name, ".coins"}, 32'(coins_left), 32'(c - 1));
            if (c == 1) begin
                chk({name, ".done"}, 32'(done), 1);
                step();
                chk({name, ".busy_off"}, 32'(busy), 0);
                chk({name, ".done_off"}, 32'(done), 0);
            end else begin
                for (int g = 0; g < 4; g++) begin
                    chk({name, ".gap"}, 32'(hopper_en), 0);
                    chk({name, ".gap_busy"}, 32'(busy), 1);
                    step();
                end
            end
        end
    endtask

    initial begin
        int d0, n;
        vecs[0] = '{3'b010, 5'd3,  3'b010, 1'b0, 5'd3,  1'b0};
        vecs[1] = '{3'b001, 5'd16, 3'b000, 1'b1, 5'd16, 1'b0};
        vecs[2] = '{3'b001, 5'd0,  3'b000, 1'b0, 5'd0,  1'b1};
        vecs[3] = '{3'b110, 5'd1,  3'b010, 1'b0, 5'd1,  1'b0};
        vecs[4] = '{3'b100, 5'd0,  3'b100, 1'b0, 5'd0,  1'b0};
        vecs[5] = '{3'b000, 5'd5,  3'b000, 1'b1, 5'd5,  1'b0};
        vecs[6] = '{3'b011, 5'd31, 3'b010, 1'b0, 5'd31, 1'b0};
        vecs[7] = '{3'b111, 5'd2,  3'b010, 1'b0, 5'd2,  1'b0};

        // Reset held with a load pending
        rst = 1'b1; item = 3'b010; change = 5'd3;
        step();
        chk_idle("rst_load");
        chk("rst_load.coins", 32'(coins_left), 0);
        chk("rst_load.ovr", 32'(overrun), 0);
        step();
        rst = 1'b0; item = '0; change = '0;
        step();
        chk("rst_rel.busy", 32'(busy), 0);

        // Load-response table
        foreach (vecs[i]) begin
            do_reset();
            item = vecs[i].item; change = vecs[i].change;
            step();
            item = '0; change = '0;
            chk($sformatf("vec%0d.motor", i), 32'(motor), 32'(vecs[i].motor));
            chk($sformatf("vec%0d.hopper", i), 32'(hopper_en), 32'(vecs[i].hopper));
            chk($sformatf("vec%0d.coins", i), 32'(coins_left), 32'(vecs[i].coins));
            chk($sformatf("vec%0d.done", i), 32'(done), 32'(vecs[i].done));
            chk($sformatf("vec%0d.busy", i), 32'(busy), 1);
        end

        // Item 010 with 3 coins
        do_reset();
        d0 = done_cnt;
        item = 3'b010; change = 5'd3;
        step();
        item = '0; change = '0;
        for (int k = 1; k < 10; k++) begin
            chk("vend.motor", 32'(motor), 32'b010);
            step();
        end
        chk("vend.motor10", 32'(motor), 32'b010);
        item_drop = 1'b1;
        step();
        chk("vend.motor_off", 32'(motor), 0);
        chk("vend.coins3", 32'(coins_left), 3);
        run_coins(3, 5, "vend");
        item_drop = 1'b0;
        chk("vend.done_pulses", 32'(done_cnt - d0), 1);

        // Refund of 16 coins
        do_reset();
        d0 = done_cnt;
        item = 3'b001; change = 5'd16;
        step();
        item = '0; change = '0;
        run_coins(16, 2, "ref16");
        chk("ref16.done_pulses", 32'(done_cnt - d0), 1);

        // Refund with zero change
        do_reset();
        item = 3'b001;
        step();
        item = '0;
        chk("ref0.done", 32'(done), 1);
        chk("ref0.motor", 32'(motor), 0);
        chk("ref0.hopper", 32'(hopper_en), 0);
        step();
        chk_idle("ref0.after");

        // Coin timeout, then fault clear with a simultaneous rejected load
        do_reset();
        change = 5'd2;
        step();
        change = '0;
        n = 0;
        while (hopper_en && n < 1100) begin
            n++;
            step();
        end
        chk("tmo.hop_cycles", 32'(n), 1000);
        chk("tmo.fault", 32'(fault), 1);
        chk("tmo.coins", 32'(coins_left), 2);
        chk("tmo.busy", 32'(busy), 1);
        step();
        chk("tmo.fault_hold", 32'(fault), 1);
        fault_clr = 1'b1; change = 5'd1;
        step();
        fault_clr = 1'b0; change = '0;
        chk("clr.fault", 32'(fault), 0);
        chk("clr.busy", 32'(busy), 0);
        chk("clr.coins", 32'(coins_left), 0);
        chk("clr.ovr", 32'(overrun), 1);
        step();
        chk("clr.ovr_off", 32'(overrun), 0);
        chk("clr.still_idle", 32'(busy), 0);

        // Overrun mid-dispense, coin edge on the terminal timeout cycle
        do_reset();
        d0 = done_cnt;
        change = 5'd1;
        step();
        change = '0;
        step(); step();
        item = 3'b100; change = 5'd5;
        step();
        item = '0; change = '0;
        chk("ovr.pulse", 32'(overrun), 1);
        chk("ovr.coins", 32'(coins_left), 1);
        chk("ovr.motor", 32'(motor), 0);
        step();
        chk("ovr.pulse_off", 32'(overrun), 0);
        for (int k = 4; k < 999; k++) begin
            if (!hopper_en) chk("term.hop_early_drop", 32'(hopper_en), 1);
            step();
        end
        chk("term.hop_last", 32'(hopper_en), 1);
        coin_sense = 1'b1;
        step();
        coin_sense = 1'b0;
        chk("term.fault", 32'(fault), 0);
        chk("term.done", 32'(done), 1);
        chk("term.coins", 32'(coins_left), 0);
        step();
        chk("term.busy_off", 32'(busy), 0);
        chk("term.done_pulses", 32'(done_cnt - d0), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
